// File: rtl/vector_instr_arb.sv
`default_nettype none
// ============================================================================
// Module      : vector_instr_arb
// Description : Round-robin arbiter over the vector instruction lanes. Each
//               granted lane index is queued in a small issue FIFO, and the
//               FIFO head is presented to the issue stage as a valid/ready
//               stream.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_instr_arb #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W    = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NUM_LANES-1:0] lane_valid,
    output logic [NUM_LANES-1:0] lane_ready,
    output logic                 issue_valid,
    output logic [LANE_W-1:0]    issue_lane,
    input  logic                 issue_ready,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [LANE_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_rst_done;
    logic [LANE_W-1:0]    r_mem [DEPTH];

    logic                 w_can_grant;
    logic                 w_found;
    logic [LANE_W-1:0]    w_grant;
    logic [LANE_W-1:0]    w_cand;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_LANES-1:0] w_ready;

    // Lane index base+off, wrapping past NUM_LANES-1 back to 0 (works for
    // lane counts that are not a power of two).
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base,
                                                   input int unsigned off);
        logic [LANE_W:0] s;
        s = {1'b0, base} + (LANE_W+1)'(off);
        if (s >= (LANE_W+1)'(NUM_LANES)) begin
            s = s - (LANE_W+1)'(NUM_LANES);
        end
        return s[LANE_W-1:0];
    endfunction

    // FIFO pointer increment with wrap at DEPTH-1 (DEPTH need not be 2^n).
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Granting depends on registered occupancy only, so issue_ready never
    // reaches lane_ready combinationally.
    assign w_can_grant = r_rst_done & enable & (r_count < CNT_W'(DEPTH));
    assign w_push      = w_can_grant & w_found;
    assign w_pop       = issue_valid & issue_ready;

    // Search from the round-robin pointer upward for the first valid lane.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_cand = lane_add(r_rr_ptr, k);
            if (!w_found && lane_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // One-hot ready for the winning lane, only when the grant really happens.
    always_comb begin
        w_ready = '0;
        if (w_push) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign lane_ready  = w_ready;
    assign issue_valid = (r_count != '0);
    assign issue_lane  = r_mem[r_rd_ptr];
    assign fifo_count  = r_count;

    // Control state: pointers, occupancy and the post-reset grant gate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_rr_ptr <= lane_add(w_grant, 1);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_grant;
        end
    end

endmodule
`default_nettype wire

// File: doc/vector_instr_arb.md
Name: vector_instr_arb

Overview:
- Downstream consumer of the vector control block's 16 instruction valid/ready lanes.
- Arbitrates the lanes round-robin, one grant per cycle.
- Pushes each granted lane index into a small issue FIFO.
- Presents the FIFO head to the vector issue stage as a single valid/ready stream carrying the lane number.

Parameters:
- NUM_LANES, 16, number of instruction lanes arbitrated.
- LANE_W, 4, width of the lane index; must equal clog2(NUM_LANES).
- DEPTH, 4, issue FIFO entries; minimum 2; need not be a power of two.
- CNT_W, 3, occupancy counter width; must equal clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = new grants allowed; 0 = no grants, FIFO keeps draining.
- lane_valid  in  NUM_LANES  bit i = instr_i_valid.
- lane_ready  out  NUM_LANES  bit i = instr_i_ready; at most one bit high per cycle.
- issue_valid  out  1  FIFO head valid.
- issue_lane  out  LANE_W  lane index at FIFO head.
- issue_ready  in  1  downstream accepts head.
- fifo_count  out  CNT_W  registered FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n low) clears the following immediately and asynchronously:
  - rr_ptr=0, wr_ptr=0, rd_ptr=0, count=0.
  - rst_done=0.
  - Outputs: issue_valid=0, fifo_count=0, lane_ready=0.
  - FIFO storage contents are don't-care.
- rst_done is set to 1 on the first clk edge after reset_n deasserts. lane_ready stays all-0 until rst_done=1, so the first grant is possible in the second cycle after release.
- can_grant = rst_done & enable & (count < DEPTH). It uses registered count only; there is no combinational path from issue_ready to lane_ready.
- Arbitration (combinational, each cycle):
  - If can_grant, search lanes rr_ptr, rr_ptr+1, ... wrapping NUM_LANES-1 to 0. The first lane with lane_valid=1 is g.
  - lane_ready = one-hot(g). If there is no valid lane or can_grant=0, lane_ready=0.
  - lane_ready may depend combinationally on lane_valid. This is permitted because the upstream valid is a pure wire from req.
- Grant (push) = can_grant and some lane valid. On a push clock edge:
  - mem[wr_ptr] <= g.
  - wr_ptr advances, wrapping DEPTH-1 to 0.
  - rr_ptr <= g+1, wrapping NUM_LANES-1 to 0.
  - No grant leaves rr_ptr unchanged.
- Pop = issue_valid & issue_ready. On a pop clock edge, rd_ptr advances with the same wrap rule.
- issue_valid = (count != 0). issue_lane = mem[rd_ptr]. Both are driven from registers/memory only.
- Occupancy update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - A push when count==DEPTH cannot occur, because can_grant is 0.
  - A pop when count==0 cannot occur, because issue_valid is 0.
- Latency: a grant in cycle N into an empty FIFO gives issue_valid=1 with that lane in cycle N+1.
- Throughput: one grant and one issue per cycle sustained while 0 < count < DEPTH.
- Full boundary: when count==DEPTH, all lane_ready=0, even if issue_ready=1 in the same cycle. Grants resume in the cycle after count drops.
- enable=0 mid-stream: grants stop the same cycle; rr_ptr holds; FIFO drains normally.
- lane_valid deasserted while not granted: no effect; there is no hold requirement on lanes.
- Reset asserted mid-operation: all state clears asynchronously. Queued entries are discarded and issue_valid falls without waiting for a clock.
- fifo_count = count (registered).

Test Plan:
1. Reset: hold reset_n=0 with lane_valid=16'hFFFF, then release. lane_ready=0 during reset and in the first cycle after release; issue_valid=0 and fifo_count=0 throughout. lane_ready[0]=1 in the second cycle after release.
2. Single request: after reset, lane_valid=16'h0020 for one cycle, issue_ready=1. lane_ready=16'h0020 that cycle. Next cycle issue_valid=1, issue_lane=5, fifo_count=1. The following cycle fifo_count=0 and issue_valid=0.
3. Fairness: lane_valid=16'hFFFF continuously, issue_ready=1. Grants follow 0,1,2,...,15,0,1, one per cycle. fifo_count stays at 1 after the first cycle.
4. Wrap and skip: lane_valid=16'h8001. Grants alternate 0,15,0,15. After granting 15, rr_ptr wraps and the next grant is lane 0.
5. Full/backpressure: lane_valid=16'h1008 (lanes 3 and 12), issue_ready=0.
   - Grants 3,12,3,12, then fifo_count=4 and lane_ready=0.
   - Raise issue_ready: issue_lane sequence is 3,12,3,12.
   - Grants restart in the first cycle after fifo_count<4; no grant occurs in the cycle the first pop happens.
6. Enable and reset mid-operation: with fifo_count=3, drop enable. No grants occur and the FIFO drains to 0. Then refill to 3 and pulse reset_n low between clock edges: issue_valid and fifo_count go to 0 immediately. After release, the first grant starts at lane 0.
